// File: rtl/uart_tx.sv
// uart_tx_fifo: circular byte buffer with registered occupancy count and full flag.
// Latency: a pushed entry is readable on rd_dat the cycle after its push edge.
// Backpressure: pushes while full are ignored; the caller sees full and drops.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Push legality uses the pre-edge full flag, so a pop on the same edge never frees room early.
    assign push   = wr_vld & ~full;
    assign rd_vld = (cnt != '0);
    assign pop    = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10: begin
                    cnt  <= cnt + CW'(1);
                    full <= (cnt == CW'(DEPTH - 1));
                end
                2'b01: begin
                    cnt  <= cnt - CW'(1);
                    full <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// uart_tx: buffered 8N1 serialiser, frames sent back-to-back while the FIFO holds data.
// Latency: write accepted at edge N, start bit driven on tx_out from edge N+1; frame is 10*CLK_DIV cycles.
// Backpressure: tx_full while FIFO_DEPTH bytes are queued; a write at full is dropped and flagged on tx_ovf.
module uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_wr,
    output logic                        tx_full,
    output logic                        tx_busy,
    output logic                        tx_ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        tx_out
);
    localparam logic [15:0] TLOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [7:0]  sh;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic        head_vld;
    logic [7:0]  head_dat;
    logic        pop;
    logic        bit_end;

    assign bit_end = (timer == 16'd0);
    assign pop     = head_vld & ((state == IDLE) | ((state == STOP) & bit_end));
    assign tx_busy = (state != IDLE) | head_vld;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (tx_wr),
        .wr_dat (tx_data),
        .rd_rdy (pop),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .cnt    (fifo_cnt),
        .full   (tx_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= 8'h00;
            timer   <= 16'd0;
            bit_idx <= 3'd0;
            tx_out  <= 1'b1;
            tx_ovf  <= 1'b0;
        end else begin
            tx_ovf <= tx_wr & tx_full;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (head_vld) begin
                        sh     <= head_dat;
                        timer  <= TLOAD;
                        tx_out <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= TLOAD;
                        bit_idx <= 3'd0;
                        tx_out  <= sh[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= TLOAD;
                        if (bit_idx == 3'd7) begin
                            tx_out <= 1'b1;
                            state  <= STOP;
                        end else begin
                            // Next bit is sh[1] because the shift lands on this same edge.
                            bit_idx <= bit_idx + 3'd1;
                            sh      <= {1'b0, sh[7:1]};
                            tx_out  <= sh[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (head_vld) begin
                            sh     <= head_dat;
                            timer  <= TLOAD;
                            tx_out <= 1'b0;
                            state  <= START;
                        end else begin
                            tx_out <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model predicts queue occupancy and line level for every cycle.
module tb_uart_tx;
    localparam int D     = 4;
    localparam int D2    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int MAXC  = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full, tx_busy, tx_ovf, tx_out;
    logic [CW-1:0] fifo_cnt;
    logic [7:0] tx_data_b;
    logic       tx_wr_b;
    logic       tx_full_b, tx_busy_b, tx_ovf_b, tx_out_b;
    logic [CW-1:0] fifo_cnt_b;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_ovf(tx_ovf),
        .fifo_cnt(fifo_cnt), .tx_out(tx_out)
    );

    uart_tx #(.CLK_DIV(D2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_wr(tx_wr_b),
        .tx_full(tx_full_b), .tx_busy(tx_busy_b), .tx_ovf(tx_ovf_b),
        .fifo_cnt(fifo_cnt_b), .tx_out(tx_out_b)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    logic samp_a [MAXC];
    logic samp_b [MAXC];

    // Line level after edge e is recorded at the following falling edge.
    always @(negedge clk) begin
        if (edge_n < MAXC) begin
            samp_a[edge_n] = tx_out;
            samp_b[edge_n] = tx_out_b;
        end
    end

    // Model: queue of bytes, plus the edge at which the current frame was popped.
    logic [7:0] m_q[$];
    bit         m_idle = 1'b1;
    int         m_pop  = 0;
    logic [7:0] m_cur  = 8'h00;
    bit         m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_idle = 1'b1;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic wr, input logic [7:0] d);
        bit full_pre;
        bit do_pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full_pre = (m_q.size() == DEPTH);
        do_pop   = 1'b0;
        if (m_idle) begin
            do_pop = (m_q.size() > 0);
        end else if (edge_n == m_pop + 10 * D) begin
            if (m_q.size() > 0) do_pop = 1'b1;
            else m_idle = 1'b1;
        end
        if (do_pop) begin
            m_cur  = m_q.pop_front();
            m_pop  = edge_n;
            m_idle = 1'b0;
        end
        if (wr && !full_pre) m_q.push_back(d);
        m_ovf = wr && full_pre;
    endtask

    function automatic logic [CW+3:0] model_status();
        int   k;
        logic line;
        if (m_idle) begin
            line = 1'b1;
        end else begin
            k = (edge_n - m_pop) / D;
            line = (k == 0) ? 1'b0 : (k >= 9) ? 1'b1 : m_cur[k-1];
        end
        return {CW'(m_q.size()), (m_q.size() == DEPTH), m_ovf,
                (!m_idle || m_q.size() > 0), line};
    endfunction

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    function automatic logic [9:0] grab_a(input int s);
        logic [9:0] f;
        for (int k = 0; k < 10; k++) f[k] = samp_a[s + k * D];
        return f;
    endfunction

    task automatic step(input logic wr, input logic [7:0] d);
        tx_wr   = wr;
        tx_data = d;
        @(posedge clk);
        edge_n++;
        model_edge(wr, d);
        @(negedge clk);
        tx_wr = 1'b0;
        chk($sformatf("status@%0d", edge_n),
            {fifo_cnt, tx_full, tx_ovf, tx_busy, tx_out}, model_status());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    initial begin
        int n0;
        int ovf_seen;
        int guard;
        logic [7:0] bytes3 [3];
        logic [19:0] obs20;
        logic [19:0] exp20;

        rst_n = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; tx_wr_b = 1'b0; tx_data_b = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_out", tx_out, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_ovf", tx_ovf, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // Single byte 0xA5
        chk("t1_idle_line", tx_out, 1);
        step(1'b1, 8'hA5);
        n0 = edge_n;
        chk("t1_cnt_after_wr", fifo_cnt, 1);
        chk("t1_busy_rise", tx_busy, 1);
        step(1'b0, 8'h5A);
        chk("t1_cnt_after_pop", fifo_cnt, 0);
        chk("t1_start_bit", tx_out, 0);
        idle(40);
        chk("t1_busy_fall", tx_busy, 0);
        chk("t1_line_before", samp_a[n0], 1);
        chk("t1_frame", grab_a(n0 + 1), 10'h34A);

        // Back-to-back 0x00, 0xFF, 0x55
        bytes3 = '{8'h00, 8'hFF, 8'h55};
        step(1'b1, bytes3[0]);
        n0 = edge_n;
        chk("t2_cnt0", fifo_cnt, 1);
        step(1'b1, bytes3[1]);
        chk("t2_cnt1", fifo_cnt, 1);
        step(1'b1, bytes3[2]);
        chk("t2_cnt2", fifo_cnt, 2);
        idle(118);
        chk("t2_busy_last_stop", tx_busy, 1);
        step(1'b0, 8'h00);
        chk("t2_busy_end", tx_busy, 0);
        for (int f = 0; f < 3; f++)
            chk($sformatf("t2_frame%0d", f), grab_a(n0 + 1 + f * 10 * D), frame_of(bytes3[f]));

        // Overflow: six writes while a frame is in flight
        step(1'b1, 8'($urandom));
        idle(5);
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom));
            ovf_seen += int'(tx_ovf);
        end
        chk("t3_full", tx_full, 1);
        chk("t3_cnt", fifo_cnt, 4);
        step(1'b0, 8'h00);
        ovf_seen += int'(tx_ovf);
        chk("t3_ovf_pulses", ovf_seen, 2);
        idle(5 * 10 * D + 5);

        // Push on the edge where STOP pops the next byte
        step(1'b1, 8'($urandom));
        idle(3);
        step(1'b1, 8'($urandom));
        guard = 0;
        while (edge_n + 1 < m_pop + 10 * D && guard < 100) begin
            step(1'b0, 8'($urandom));
            guard++;
        end
        chk("t4_reach_stop_end", guard < 100, 1);
        step(1'b1, 8'($urandom));
        chk("t4_cnt_pushpop", fifo_cnt, 1);
        idle(3 * 10 * D);

        // Reset during bit 3 of 0x3C with two bytes queued
        step(1'b1, 8'h3C);
        n0 = edge_n;
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        chk("t5_queued", fifo_cnt, 2);
        idle(16);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_line", tx_out, 1);
        chk("t5_rst_cnt", fifo_cnt, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        step(1'b1, 8'h81);
        n0 = edge_n;
        idle(10 * D + 2);
        chk("t5_frame_81", grab_a(n0 + 1), frame_of(8'h81));
        chk("t5_busy_end", tx_busy, 0);

        // Random traffic against the model
        repeat (300) step(($urandom_range(0, 19) == 0), 8'($urandom));
        idle(6 * 10 * D);

        // CLK_DIV = 2 instance, byte 0x01
        tx_wr_b = 1'b1;
        tx_data_b = 8'h01;
        step(1'b0, 8'h00);
        n0 = edge_n;
        tx_wr_b = 1'b0;
        tx_data_b = 8'hFE;
        idle(22);
        for (int k = 0; k < 20; k++) begin
            obs20[k] = samp_b[n0 + 1 + k];
            exp20[k] = frame_of(8'h01)[k / 2];
        end
        chk("t7_frame20", obs20, exp20);
        chk("t7_line_before", samp_b[n0], 1);
        chk("t7_line_after", samp_b[n0 + 21], 1);
        chk("t7_busy_end", tx_busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
